// File: rtl/fwrisc_pkg.sv
// Shared types and widths for the fwrisc decode / operand-fetch boundary.
package fwrisc_pkg;

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 32;
  localparam int unsigned TW    = 32;
  localparam int unsigned NREGS = 2 ** AW;

  typedef logic [AW-1:0] reg_addr_t;

  // Decoded instruction as handed from decode to operand fetch.
  typedef struct packed {
    reg_addr_t       rs1;
    reg_addr_t       rs2;
    logic            use_rs1;
    logic            use_rs2;
    reg_addr_t       rd;
    logic            rd_wen;
    logic [TW-1:0]   tag;
  } fetch_instr_t;

  // Enabled address compare.
  function automatic logic addr_hit(input logic en, input reg_addr_t a, input reg_addr_t b);
    return en && (a == b);
  endfunction

  // A source stalls on an in-flight producer, or on a scoreboard bit not being retired this cycle.
  function automatic logic src_hazard(input logic use_rs, input reg_addr_t rs,
                                      input logic sb_hit, input logic wb_hit,
                                      input logic s1_hit, input logic out_hit);
    return use_rs && (rs != '0) && ((sb_hit && !wb_hit) || s1_hit || out_hit);
  endfunction

endpackage

// File: rtl/fwrisc_operand_fetch_if.sv
// Decode, regfile, writeback and execute signals seen by the operand-fetch stage.
interface fwrisc_operand_fetch_if;
  import fwrisc_pkg::*;

  logic            in_valid;
  logic            in_ready;
  reg_addr_t       in_rs1;
  reg_addr_t       in_rs2;
  logic            in_use_rs1;
  logic            in_use_rs2;
  reg_addr_t       in_rd;
  logic            in_rd_wen;
  logic [TW-1:0]   in_tag;

  reg_addr_t       ra_raddr;
  reg_addr_t       rb_raddr;
  logic [DW-1:0]   ra_rdata;
  logic [DW-1:0]   rb_rdata;

  reg_addr_t       wb_waddr;
  logic            wb_wen;

  logic            op_valid;
  logic            op_ready;
  logic [DW-1:0]   op_a;
  logic [DW-1:0]   op_b;
  reg_addr_t       op_rd;
  logic            op_rd_wen;
  logic [TW-1:0]   op_tag;

  logic            flush;

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_rd_wen, in_tag,
    input  ra_rdata, rb_rdata, wb_waddr, wb_wen, op_ready, flush,
    output in_ready, ra_raddr, rb_raddr,
    output op_valid, op_a, op_b, op_rd, op_rd_wen, op_tag
  );

  modport master (
    output in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_rd_wen, in_tag,
    output ra_rdata, rb_rdata, wb_waddr, wb_wen, op_ready, flush,
    input  in_ready, ra_raddr, rb_raddr,
    input  op_valid, op_a, op_b, op_rd, op_rd_wen, op_tag
  );

endinterface

// File: rtl/fwrisc_scoreboard.sv
// One pending-write bit per register; set wins over a same-cycle clear, entry 0 never pends.
module fwrisc_scoreboard
  import fwrisc_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      set_en_i,
  input  reg_addr_t set_addr_i,
  input  logic      clr_en_i,
  input  reg_addr_t clr_addr_i,
  input  reg_addr_t lookup_a_i,
  input  reg_addr_t lookup_b_i,
  output logic      hit_a_c,
  output logic      hit_b_c
);

  logic [NREGS-1:0] sb_q;
  logic [NREGS-1:0] sb_d;

  // Clear first so a simultaneous set on the same entry survives; bit 0 is forced low last.
  always_comb begin
    sb_d = sb_q;
    if (clr_en_i) sb_d[clr_addr_i] = 1'b0;
    if (set_en_i) sb_d[set_addr_i] = 1'b1;
    sb_d[0] = 1'b0;
  end

  // Scoreboard state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb_q <= '0;
    else        sb_q <= sb_d;
  end

  assign hit_a_c = sb_q[lookup_a_i];
  assign hit_b_c = sb_q[lookup_b_i];

endmodule

// File: rtl/fwrisc_operand_fetch.sv
// Register-read stage: issues regfile reads, tracks pending writes, hands operands to execute.
module fwrisc_operand_fetch
  import fwrisc_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  fwrisc_operand_fetch_if.slave  of_if
);

  fetch_instr_t   in_instr_c;
  fetch_instr_t   s1_q, s1_d;
  logic           s1_valid_q, s1_valid_d;
  logic           out_valid_q, out_valid_d;
  logic [DW-1:0]  op_a_q, op_a_d;
  logic [DW-1:0]  op_b_q, op_b_d;
  reg_addr_t      op_rd_q, op_rd_d;
  logic           op_rd_wen_q, op_rd_wen_d;
  logic [TW-1:0]  op_tag_q, op_tag_d;

  logic read_adv_c;
  logic out_fire_c;
  logic sb_hit_a_c, sb_hit_b_c;
  logic hazard_a_c, hazard_b_c;
  logic in_ready_c;
  logic accept_c;

  // Pack the incoming decode fields.
  always_comb begin
    in_instr_c         = '0;
    in_instr_c.rs1     = of_if.in_rs1;
    in_instr_c.rs2     = of_if.in_rs2;
    in_instr_c.use_rs1 = of_if.in_use_rs1;
    in_instr_c.use_rs2 = of_if.in_use_rs2;
    in_instr_c.rd      = of_if.in_rd;
    in_instr_c.rd_wen  = of_if.in_rd_wen;
    in_instr_c.tag     = of_if.in_tag;
  end

  assign read_adv_c = !out_valid_q || of_if.op_ready;
  assign out_fire_c = out_valid_q && of_if.op_ready;

  fwrisc_scoreboard u_sb (
    .clk        (clock),
    .rst_n      (reset),
    .set_en_i   (out_fire_c && op_rd_wen_q),
    .set_addr_i (op_rd_q),
    .clr_en_i   (of_if.wb_wen),
    .clr_addr_i (of_if.wb_waddr),
    .lookup_a_i (of_if.in_rs1),
    .lookup_b_i (of_if.in_rs2),
    .hit_a_c    (sb_hit_a_c),
    .hit_b_c    (sb_hit_b_c)
  );

  // RAW hazard per source against scoreboard, READ and OUT producers.
  always_comb begin
    hazard_a_c = src_hazard(in_instr_c.use_rs1, in_instr_c.rs1, sb_hit_a_c,
                            addr_hit(of_if.wb_wen, of_if.wb_waddr, in_instr_c.rs1),
                            addr_hit(s1_valid_q && s1_q.rd_wen, s1_q.rd, in_instr_c.rs1),
                            addr_hit(out_valid_q && op_rd_wen_q, op_rd_q, in_instr_c.rs1));
    hazard_b_c = src_hazard(in_instr_c.use_rs2, in_instr_c.rs2, sb_hit_b_c,
                            addr_hit(of_if.wb_wen, of_if.wb_waddr, in_instr_c.rs2),
                            addr_hit(s1_valid_q && s1_q.rd_wen, s1_q.rd, in_instr_c.rs2),
                            addr_hit(out_valid_q && op_rd_wen_q, op_rd_q, in_instr_c.rs2));
  end

  assign in_ready_c = !(hazard_a_c || hazard_b_c) && (!s1_valid_q || read_adv_c) && !of_if.flush;
  assign accept_c   = of_if.in_valid && in_ready_c;

  // A stalled READ keeps re-reading its own sources so the captured data is never stale.
  assign of_if.ra_raddr = (s1_valid_q && !read_adv_c) ? s1_q.rs1 : of_if.in_rs1;
  assign of_if.rb_raddr = (s1_valid_q && !read_adv_c) ? s1_q.rs2 : of_if.in_rs2;

  // Next state for READ and OUT; flush empties both but leaves the scoreboard alone.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_d        = s1_q;
    out_valid_d = out_valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    op_rd_d     = op_rd_q;
    op_rd_wen_d = op_rd_wen_q;
    op_tag_d    = op_tag_q;

    if (!s1_valid_q || read_adv_c) begin
      s1_valid_d = accept_c;
      if (accept_c) s1_d = in_instr_c;
    end

    if (read_adv_c) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        op_a_d      = s1_q.use_rs1 ? of_if.ra_rdata : '0;
        op_b_d      = s1_q.use_rs2 ? of_if.rb_rdata : '0;
        op_rd_d     = s1_q.rd;
        op_rd_wen_d = s1_q.rd_wen;
        op_tag_d    = s1_q.tag;
      end
    end

    if (of_if.flush) begin
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  // Pipeline registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_q        <= '0;
      out_valid_q <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      op_rd_q     <= '0;
      op_rd_wen_q <= 1'b0;
      op_tag_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_q        <= s1_d;
      out_valid_q <= out_valid_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      op_rd_q     <= op_rd_d;
      op_rd_wen_q <= op_rd_wen_d;
      op_tag_q    <= op_tag_d;
    end
  end

  assign of_if.in_ready  = in_ready_c;
  assign of_if.op_valid  = out_valid_q;
  assign of_if.op_a      = op_a_q;
  assign of_if.op_b      = op_b_q;
  assign of_if.op_rd     = op_rd_q;
  assign of_if.op_rd_wen = op_rd_wen_q;
  assign of_if.op_tag    = op_tag_q;

endmodule

// File: tb/tb_fwrisc_operand_fetch.sv
// Bench for fwrisc_operand_fetch: regfile model, expected-result queue, vector table plus corner sequences.
module tb_fwrisc_operand_fetch;
  import fwrisc_pkg::*;

  typedef struct {
    reg_addr_t   rs1;
    reg_addr_t   rs2;
    logic        u1;
    logic        u2;
    reg_addr_t   rd;
    logic        wen;
    logic [31:0] tag;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    reg_addr_t   rd;
    logic        wen;
    logic [31:0] tag;
    int          acc;
    int          lat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  exp_t sbq[$];
  exp_t mon_e;

  bit   [DW-1:0] rf [NREGS];
  logic [DW-1:0] wb_wdata;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fwrisc_operand_fetch_if bus();

  fwrisc_operand_fetch dut (
    .clock (clk),
    .reset (rst_n),
    .of_if (bus)
  );

  // Regfile: synchronous read with write-through of a same-edge writeback.
  function automatic logic [DW-1:0] rd_val(input reg_addr_t a);
    if (a == '0) return '0;
    if (bus.wb_wen && bus.wb_waddr == a) return wb_wdata;
    return rf[a];
  endfunction

  always @(posedge clk) begin
    if (bus.wb_wen && bus.wb_waddr != '0) rf[bus.wb_waddr] <= wb_wdata;
    bus.ra_rdata <= rd_val(bus.ra_raddr);
    bus.rb_rdata <= rd_val(bus.rb_raddr);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output side: pop the oldest expectation on every execute handshake.
  always @(negedge clk) begin
    if (rst_n && bus.op_valid && bus.op_ready) begin
      if (sbq.size() == 0) begin
        check("unexpected_op", {32'd0, bus.op_tag}, 64'hFFFF_FFFF);
      end else begin
        mon_e = sbq.pop_front();
        check("op_a", bus.op_a, mon_e.a);
        check("op_b", bus.op_b, mon_e.b);
        check("op_rd", bus.op_rd, mon_e.rd);
        check("op_rd_wen", bus.op_rd_wen, mon_e.wen);
        check("op_tag", bus.op_tag, mon_e.tag);
        if (mon_e.lat != 0) check("latency", 64'(cyc - mon_e.acc), 64'(mon_e.lat));
      end
    end
  end

  function automatic vec_t mk(input int rs1, input int rs2, input bit u1, input bit u2,
                              input int rd, input bit wen, input logic [31:0] tag,
                              input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    v.rs1 = AW'(rs1); v.rs2 = AW'(rs2); v.u1 = u1; v.u2 = u2;
    v.rd = AW'(rd); v.wen = wen; v.tag = tag; v.a = a; v.b = b;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wb(input int a, input logic [31:0] d);
    bus.wb_wen   = 1'b1;
    bus.wb_waddr = AW'(a);
    wb_wdata     = d;
    tick();
    bus.wb_wen   = 1'b0;
  endtask

  // Present one instruction until accepted; record the acceptance cycle and queue its result.
  task automatic issue(input vec_t v, input int lat, output int acc);
    exp_t e;
    bus.in_rs1 = v.rs1; bus.in_rs2 = v.rs2;
    bus.in_use_rs1 = v.u1; bus.in_use_rs2 = v.u2;
    bus.in_rd = v.rd; bus.in_rd_wen = v.wen; bus.in_tag = v.tag;
    bus.in_valid = 1'b1;
    acc = -1;
    for (int i = 0; i < 40 && acc < 0; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = cyc;
        e.a = v.a; e.b = v.b; e.rd = v.rd; e.wen = v.wen; e.tag = v.tag;
        e.acc = cyc; e.lat = lat;
        sbq.push_back(e);
      end
      tick();
    end
    bus.in_valid = 1'b0;
    if (acc < 0) check("issue_timeout", {32'd0, v.tag}, 64'd0);
  endtask

  task automatic wait_op_valid(input string name);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      seen = bus.op_valid;
      tick();
    end
    if (!seen) check(name, 64'd0, 64'd1);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && sbq.size() != 0; i++) tick();
    if (sbq.size() != 0) check(name, 64'(sbq.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [8];
    int   acc [8];
    int   a0, a1, wbcyc, st;

    tbl[0] = mk(1,  2,  1, 1, 10, 1, 32'h100, 32'h1111_1111, 32'h2222_2222);
    tbl[1] = mk(3,  4,  0, 1, 11, 0, 32'h101, 32'h0,         32'h4444_4444);
    tbl[2] = mk(0,  1,  1, 1, 0,  1, 32'h102, 32'h0,         32'h1111_1111);
    tbl[3] = mk(2,  3,  1, 0, 0,  0, 32'h103, 32'h2222_2222, 32'h0);
    tbl[4] = mk(4,  4,  1, 1, 0,  0, 32'h104, 32'h4444_4444, 32'h4444_4444);
    tbl[5] = mk(63, 1,  1, 1, 0,  0, 32'h105, 32'hFFFF_0000, 32'h1111_1111);
    tbl[6] = mk(10, 0,  0, 1, 0,  0, 32'h106, 32'h0,         32'h0);
    tbl[7] = mk(12, 13, 1, 1, 12, 1, 32'h107, 32'h0C0C_0C0C, 32'h0D0D_0D0D);

    bus.in_valid = 1'b0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_use_rs1 = 1'b0; bus.in_use_rs2 = 1'b0;
    bus.in_rd = '0; bus.in_rd_wen = 1'b0; bus.in_tag = '0;
    bus.wb_wen = 1'b0; bus.wb_waddr = '0; wb_wdata = '0;
    bus.op_ready = 1'b1; bus.flush = 1'b0;

    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_op_valid", bus.op_valid, 0);
    check("rst_op_a", bus.op_a, 0);
    check("rst_op_b", bus.op_b, 0);
    check("rst_op_rd", bus.op_rd, 0);
    check("rst_op_rd_wen", bus.op_rd_wen, 0);
    check("rst_op_tag", bus.op_tag, 0);
    tick();

    // Test 1: single read of a freshly written register.
    wb(5, 32'h1234_5678);
    issue(mk(5, 0, 1, 1, 0, 0, 32'h001, 32'h1234_5678, 32'h0), 2, a0);
    wait_drain("t1_drain");

    // Register file contents for the table.
    wb(1, 32'h1111_1111); wb(2, 32'h2222_2222); wb(3, 32'h3333_3333);
    wb(4, 32'h4444_4444); wb(63, 32'hFFFF_0000); wb(12, 32'h0C0C_0C0C);
    wb(13, 32'h0D0D_0D0D); wb(30, 32'h3030_3030);

    // Table: independent instructions back to back at one per cycle.
    for (int i = 0; i < 8; i++) issue(tbl[i], 2, acc[i]);
    for (int i = 1; i < 8; i++) check("throughput", 64'(acc[i] - acc[0]), 64'(i));
    wait_drain("tbl_drain");
    wb(10, 32'hA0A0_A0A0);
    wb(12, 32'h0C0C_0C0C);

    // Test 2: consumer waits through READ, OUT and scoreboard, released by the writeback.
    issue(mk(0, 0, 0, 0, 7, 1, 32'h200, 32'h0, 32'h0), 2, a0);
    fork
      issue(mk(7, 0, 1, 0, 0, 0, 32'h201, 32'hDEAD_BEEF, 32'h0), 2, a1);
      begin
        repeat (6) tick();
        wbcyc = cyc;
        wb(7, 32'hDEAD_BEEF);
      end
    join
    check("t2_accept_on_wb", 64'(a1), 64'(wbcyc));
    wait_drain("t2_drain");

    // Test 3: READ stalled behind a blocked OUT re-reads a source written mid-stall.
    bus.op_ready = 1'b0;
    issue(mk(1, 2, 1, 1, 0, 0, 32'h300, 32'h1111_1111, 32'h2222_2222), 0, a0);
    issue(mk(3, 20, 1, 1, 0, 0, 32'h301, 32'h3333_3333, 32'hCAFE_F00D), 0, a1);
    bus.in_rs1 = AW'(4);
    bus.in_rs2 = AW'(1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.wb_wen = 1'b1; bus.wb_waddr = AW'(20); wb_wdata = 32'hCAFE_F00D;
      end
      @(negedge clk);
      check("t3_op_valid", bus.op_valid, 1);
      check("t3_op_a_stable", bus.op_a, 32'h1111_1111);
      check("t3_op_tag_stable", bus.op_tag, 32'h300);
      check("t3_in_ready", bus.in_ready, 0);
      tick();
      bus.wb_wen = 1'b0;
    end
    bus.op_ready = 1'b1;
    wait_drain("t3_drain");

    // Test 4: flush with READ and OUT occupied; the OUT handshake that cycle still counts.
    bus.op_ready = 1'b0;
    issue(mk(0, 0, 0, 0, 21, 1, 32'h400, 32'h0, 32'h0), 0, a0);
    issue(mk(0, 0, 0, 0, 0, 0, 32'h401, 32'h0, 32'h0), 0, a1);
    bus.flush = 1'b1;
    bus.op_ready = 1'b1;
    @(negedge clk);
    check("t4_flush_in_ready", bus.in_ready, 0);
    check("t4_flush_op_valid", bus.op_valid, 1);
    tick();
    bus.flush = 1'b0;
    if (sbq.size() != 0) void'(sbq.pop_back());
    @(negedge clk);
    check("t4_after_flush_op_valid", bus.op_valid, 0);
    tick();
    @(negedge clk);
    check("t4_s1_cleared", bus.op_valid, 0);
    tick();
    fork
      issue(mk(21, 0, 1, 0, 0, 0, 32'h402, 32'h2121_2121, 32'h0), 2, a1);
      begin
        repeat (4) tick();
        wbcyc = cyc;
        wb(21, 32'h2121_2121);
      end
    join
    check("t4_accept_on_wb", 64'(a1), 64'(wbcyc));
    wait_drain("t4_drain");

    // Test 5: same-cycle set and clear on x9 leaves the bit pending.
    issue(mk(0, 0, 0, 0, 9, 1, 32'h500, 32'h0, 32'h0), 2, a0);
    wait_drain("t5_drain_y");
    tick();
    bus.op_ready = 1'b0;
    issue(mk(0, 0, 0, 0, 9, 1, 32'h501, 32'h0, 32'h0), 0, a0);
    wait_op_valid("t5_op_valid_timeout");
    bus.op_ready = 1'b1;
    wb(9, 32'h9999_9999);
    fork
      issue(mk(0, 9, 0, 1, 0, 0, 32'h502, 32'h0, 32'h9090_9090), 2, a1);
      begin
        repeat (5) tick();
        wbcyc = cyc;
        wb(9, 32'h9090_9090);
      end
    join
    check("t5_accept_on_second_wb", 64'(a1), 64'(wbcyc));
    wait_drain("t5_drain");

    // Test 6: asynchronous reset mid-stream clears OUT and the scoreboard.
    issue(mk(0, 0, 0, 0, 30, 1, 32'h600, 32'h0, 32'h0), 2, a0);
    wait_drain("t6_drain_r0");
    tick();
    bus.op_ready = 1'b0;
    issue(mk(0, 0, 0, 0, 0, 0, 32'h601, 32'h0, 32'h0), 0, a0);
    wait_op_valid("t6_op_valid_timeout");
    check("t6_op_valid_before_reset", bus.op_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t6_async_op_valid", bus.op_valid, 0);
    check("t6_async_op_tag", bus.op_tag, 0);
    sbq.delete();
    tick();
    rst_n = 1'b1;
    bus.op_ready = 1'b1;
    @(negedge clk);
    check("t6_in_ready", bus.in_ready, 1);
    check("t6_op_valid", bus.op_valid, 0);
    check("t6_op_rd_wen", bus.op_rd_wen, 0);
    tick();
    st = cyc;
    issue(mk(30, 0, 1, 0, 0, 0, 32'h602, 32'h3030_3030, 32'h0), 2, a1);
    check("t6_sb_cleared", 64'(a1), 64'(st));
    wait_drain("t6_drain");

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
